// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-extension pipeline.
//   imm_fmt_t      : immediate format selector encodings (3 bits)
//   *_LSB / *_MSB  : instruction-word bit positions of each immediate field
//   DATA_W_NARROW/WIDE and data_w_legal(): the supported output widths
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_IMM12  = 3'd0,
    FMT_DADDR9 = 3'd1,
    FMT_CB19   = 3'd2,
    FMT_B26    = 3'd3,
    FMT_MOV16  = 3'd4,
    FMT_SHAMT6 = 3'd5,
    FMT_RSVD6  = 3'd6,
    FMT_RSVD7  = 3'd7
  } imm_fmt_t;

  localparam int IMM12_LSB  = 10;
  localparam int IMM12_MSB  = 21;
  localparam int DADDR9_LSB = 12;
  localparam int DADDR9_MSB = 20;
  localparam int CB19_LSB   = 5;
  localparam int CB19_MSB   = 23;
  localparam int B26_LSB    = 0;
  localparam int B26_MSB    = 25;
  localparam int MOV16_LSB  = 5;
  localparam int MOV16_MSB  = 20;
  localparam int HW_LSB     = 21;
  localparam int HW_MSB     = 22;
  localparam int SHAMT6_LSB = 10;
  localparam int SHAMT6_MSB = 15;

  localparam int DATA_W_NARROW = 32;
  localparam int DATA_W_WIDE   = 64;

  function automatic bit data_w_legal(int w);
    return (w == DATA_W_NARROW) || (w == DATA_W_WIDE);
  endfunction

endpackage

// File: rtl/imm_field_ext.sv
// Combinational immediate field selection and extension.
//   instr   [31:0]       : instruction word
//   fmt     [2:0]        : format selector (imm_fmt_t encoding)
//   imm     [DATA_W-1:0] : extended immediate, 0 for reserved formats
//   illegal              : fmt is a reserved encoding
// The immediate is always built 64 bits wide and then truncated, so a
// 32-bit build drops MOV16 halfwords 2 and 3 naturally.
module imm_field_ext
  import imm_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [31:0]       instr,
  input  logic [2:0]        fmt,
  output logic [DATA_W-1:0] imm,
  output logic              illegal
);

  logic [63:0] wide;
  logic [5:0]  mov_shift;
  logic [5:0]  unused_instr;

  // Bits [31:26] hold the opcode and carry no immediate.
  assign unused_instr = instr[31:26];
  // Halfword index times 16.
  assign mov_shift    = {instr[HW_MSB:HW_LSB], 4'b0000};

  // NOTE: every always_comb output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wide    = '0;
    illegal = 1'b0;
    case (imm_fmt_t'(fmt))
      FMT_IMM12:  wide = 64'(instr[IMM12_MSB:IMM12_LSB]);
      FMT_DADDR9: wide = 64'(signed'(instr[DADDR9_MSB:DADDR9_LSB]));
      FMT_CB19:   wide = 64'(signed'({instr[CB19_MSB:CB19_LSB], 2'b00}));
      FMT_B26:    wide = 64'(signed'({instr[B26_MSB:B26_LSB], 2'b00}));
      FMT_MOV16:  wide = 64'(instr[MOV16_MSB:MOV16_LSB]) << mov_shift;
      FMT_SHAMT6: wide = 64'(instr[SHAMT6_MSB:SHAMT6_LSB]);
      default:    illegal = 1'b1;
    endcase
  end

  assign imm = wide[DATA_W-1:0];

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate-extension pipeline: extends the immediate of an accepted
// instruction combinationally and registers it into a small FIFO.
//   clk, reset_n      : clock, asynchronous active-low reset
//   flush             : synchronous discard of all buffered entries
//   in_valid/in_ready : input handshake for instr/fmt
//   instr, fmt        : instruction word and immediate format
//   out_valid/out_ready, out_imm : output handshake and extended immediate
//   fmt_err           : sticky, set when a reserved fmt was accepted
// in_ready depends only on registered state, never on out_ready, so a full
// buffer cannot accept a push even on an edge where it also pops.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [2:0]        fmt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic              fmt_err
);

  if (!(data_w_legal(DATA_W) && (DEPTH == 1 || DEPTH == 2))) begin : g_bad_params
    $error("imm_extend_pipe: DATA_W must be 32 or 64 and DEPTH must be 1 or 2");
  end

  localparam logic [1:0] DEPTH_C  = 2'(DEPTH);
  localparam logic       PTR_LAST = 1'(DEPTH - 1);

  logic [DATA_W-1:0] ext_imm;
  logic              ext_illegal;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              ready_en;   // low in reset, high from the first edge after
  logic              push;
  logic              pop;

  function automatic logic ptr_inc(logic p);
    return (p == PTR_LAST) ? 1'b0 : ~p;
  endfunction

  imm_field_ext #(.DATA_W(DATA_W)) u_field_ext (
    .instr   (instr),
    .fmt     (fmt),
    .imm     (ext_imm),
    .illegal (ext_illegal)
  );

  assign in_ready  = ready_en && (count < DEPTH_C);
  assign out_valid = (count != 2'd0);
  assign out_imm   = mem[rd_ptr];

  // A flush edge ignores both handshakes; the buffer is emptied instead.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the storage is reset because out_imm reads it directly and
      // must show 0 in reset; at two entries this costs almost nothing.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      ready_en <= 1'b0;
      fmt_err  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= ext_imm;
          wr_ptr      <= ptr_inc(wr_ptr);
          if (ext_illegal) fmt_err <= 1'b1;
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe (DATA_W=64, DEPTH=2).
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [2:0]  fmt;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_imm;
  logic        fmt_err;

  int checks = 0;
  int errors = 0;

  imm_extend_pipe #(.DATA_W(64), .DEPTH(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .fmt       (fmt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .fmt_err   (fmt_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one input for one edge with out_ready high; result shows 1 cycle later.
  task automatic push_check(input string tag, input logic [2:0] f,
                            input logic [31:0] i, input logic [63:0] e);
    in_valid = 1'b1;
    fmt      = f;
    instr    = i;
    tick();
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".imm"}, out_imm, e);
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    instr = '0; fmt = '0; out_ready = 1'b0;

    // Reset state
    #12;
    check("rst.in_ready", 64'(in_ready), 64'd0);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out_imm", out_imm, 64'd0);
    check("rst.fmt_err", 64'(fmt_err), 64'd0);
    #1 reset_n = 1'b1;
    check("rel.in_ready_before_edge", 64'(in_ready), 64'd0);
    tick();
    check("rel.in_ready_after_edge", 64'(in_ready), 64'd1);
    check("rel.out_valid", 64'(out_valid), 64'd0);

    // Format sweep with all-ones instruction, then distinct patterns
    out_ready = 1'b1;
    push_check("imm12_ones",  3'd0, 32'hFFFF_FFFF, 64'h0000_0000_0000_0FFF);
    push_check("daddr9_ones", 3'd1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    push_check("cb19_ones",   3'd2, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC);
    push_check("b26_ones",    3'd3, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC);
    push_check("mov16_ones",  3'd4, 32'hFFFF_FFFF, 64'hFFFF_0000_0000_0000);
    push_check("shamt6_ones", 3'd5, 32'hFFFF_FFFF, 64'h0000_0000_0000_003F);
    push_check("imm12_abc",   3'd0, 32'h002A_F000, 64'h0000_0000_0000_0ABC);
    push_check("daddr9_pos",  3'd1, 32'h0000_F000, 64'h0000_0000_0000_000F);
    push_check("cb19_four",   3'd2, 32'h0000_0020, 64'h0000_0000_0000_0004);
    push_check("b26_minneg",  3'd3, 32'h0200_0000, 64'hFFFF_FFFF_F800_0000);
    push_check("mov16_hw1",   3'd4, 32'h0022_4680, 64'h0000_0000_1234_0000);
    push_check("shamt6_23",   3'd5, 32'h0000_8C00, 64'h0000_0000_0000_0023);
    in_valid = 1'b0;
    tick();
    check("sweep.drained", 64'(out_valid), 64'd0);
    check("sweep.fmt_err", 64'(fmt_err), 64'd0);

    // Backpressure: three attempted pushes into a 2-entry buffer
    out_ready = 1'b0;
    in_valid  = 1'b1; fmt = 3'd0;
    instr = 32'd1 << 10; tick();
    check("bp.ready_after1", 64'(in_ready), 64'd1);
    check("bp.head_after1", out_imm, 64'd1);
    instr = 32'd2 << 10; tick();
    check("bp.ready_full", 64'(in_ready), 64'd0);
    check("bp.head_full", out_imm, 64'd1);
    instr = 32'd3 << 10; tick();
    check("bp.ready_hold", 64'(in_ready), 64'd0);
    check("bp.head_hold", out_imm, 64'd1);
    out_ready = 1'b1; tick();
    check("bp.drain_b", out_imm, 64'd2);
    check("bp.ready_reopen", 64'(in_ready), 64'd1);
    tick();
    check("bp.drain_c_valid", 64'(out_valid), 64'd1);
    check("bp.drain_c", out_imm, 64'd3);
    in_valid = 1'b0; tick();
    check("bp.empty", 64'(out_valid), 64'd0);

    // Streaming: one transfer per cycle for 100 cycles
    in_valid = 1'b1; out_ready = 1'b1; fmt = 3'd0;
    for (int i = 0; i < 100; i++) begin
      instr = 32'(i) << 10;
      tick();
      check("stream.valid", 64'(out_valid), 64'd1);
      check("stream.imm", out_imm, 64'(i));
      check("stream.in_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0; tick();
    check("stream.empty", 64'(out_valid), 64'd0);

    // Flush while full, with a simultaneous input
    out_ready = 1'b0; in_valid = 1'b1; fmt = 3'd0;
    instr = 32'h11 << 10; tick();
    instr = 32'h22 << 10; tick();
    check("flush_full.ready", 64'(in_ready), 64'd0);
    flush = 1'b1; instr = 32'h77 << 10; tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_full.valid", 64'(out_valid), 64'd0);
    check("flush_full.in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1; tick();
    check("flush_full.stays_empty", 64'(out_valid), 64'd0);

    // Flush with one entry: the in-flight handshake on the flush edge is dropped
    out_ready = 1'b0; in_valid = 1'b1;
    instr = 32'h33 << 10; tick();
    flush = 1'b1; instr = 32'h77 << 10; tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_one.valid", 64'(out_valid), 64'd0);
    tick();
    check("flush_one.no_ghost", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    push_check("flush_one.next", 3'd0, 32'h44 << 10, 64'h44);
    in_valid = 1'b0; tick();
    check("flush_one.empty", 64'(out_valid), 64'd0);

    // Illegal formats
    check("illegal.pre_err", 64'(fmt_err), 64'd0);
    push_check("illegal7", 3'd7, 32'hFFFF_FFFF, 64'd0);
    check("illegal7.err", 64'(fmt_err), 64'd1);
    push_check("illegal6", 3'd6, 32'hFFFF_FFFF, 64'd0);
    in_valid = 1'b0;
    flush = 1'b1; tick();
    flush = 1'b0;
    check("illegal.err_after_flush", 64'(fmt_err), 64'd1);
    check("illegal.flushed", 64'(out_valid), 64'd0);
    tick();
    check("illegal.err_sticky", 64'(fmt_err), 64'd1);

    // Asynchronous reset between edges with a full buffer
    out_ready = 1'b0; in_valid = 1'b1; fmt = 3'd0;
    instr = 32'h55 << 10; tick();
    instr = 32'h66 << 10; tick();
    in_valid = 1'b0;
    check("areset.full_valid", 64'(out_valid), 64'd1);
    check("areset.full_ready", 64'(in_ready), 64'd0);
    #3 reset_n = 1'b0;
    #1;
    check("areset.valid", 64'(out_valid), 64'd0);
    check("areset.in_ready", 64'(in_ready), 64'd0);
    check("areset.imm", out_imm, 64'd0);
    check("areset.fmt_err", 64'(fmt_err), 64'd0);
    #2 reset_n = 1'b1;
    tick();
    check("areset.ready_back", 64'(in_ready), 64'd1);
    check("areset.no_stale", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    push_check("areset.first", 3'd0, 32'h5A5 << 10, 64'h5A5);
    in_valid = 1'b0; tick();
    check("areset.empty", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 64: width of the extended immediate; legal values are 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 2: output buffer entries; legal values are 1 and 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port flush, input, 1 bit: synchronous discard of all buffered entries.
REQ-006 SHALL have port in_valid, input, 1 bit: instr and fmt are valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts input this cycle.
REQ-008 SHALL have port instr, input, 32 bits: instruction word.
REQ-009 SHALL have port fmt, input, 3 bits: immediate format selector (encodings in REQ-014).
REQ-010 SHALL have port out_valid, output, 1 bit: out_imm is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts out_imm.
REQ-012 SHALL have port out_imm, output, DATA_W bits: extended immediate.
REQ-013 SHALL have port fmt_err, output, 1 bit: sticky flag; an illegal fmt was accepted.

Function
REQ-014 SHALL decode fmt as follows:
- 0 IMM12: zero-extend instr[21:10].
- 1 DADDR9: sign-extend instr[20:12].
- 2 CB19: sign-extend {instr[23:5],2'b00}.
- 3 B26: sign-extend {instr[25:0],2'b00}.
- 4 MOV16: zero-extend instr[20:5], then shift left by 16*instr[22:21].
- 5 SHAMT6: zero-extend instr[15:10].
REQ-015 SHALL treat fmt 6 and 7 as illegal: the entry is enqueued with out_imm = 0 and fmt_err is set at the next edge.
REQ-016 SHALL truncate to DATA_W bits when DATA_W = 32; for MOV16 with instr[22:21] >= 2, out_imm = 0.
REQ-017 SHALL compute the extension combinationally and register it; latency from input handshake to out_valid is exactly 1 cycle.
REQ-018 SHALL complete an input transfer only on an edge where in_valid && in_ready, and an output transfer only on an edge where out_valid && out_ready.
REQ-019 SHALL buffer entries in a FIFO of DEPTH entries with occupancy count 0..DEPTH; out_valid = (count != 0).
REQ-020 SHALL derive in_ready from registered state only, with no combinational path from out_ready:
- in_ready = (count < DEPTH).
- For DEPTH = 1: in_ready = (count == 0).
REQ-021 SHALL, when DEPTH = 2 and count = 1, sustain one transfer per cycle if in and out handshakes occur together; count stays 1.
REQ-022 SHALL, when full (count = DEPTH), deassert in_ready; a simultaneous output pop does not admit a push on the same edge.
REQ-023 SHALL hold out_imm stable while out_valid && !out_ready.
REQ-024 SHALL wrap the read and write pointers modulo DEPTH.
REQ-025 SHALL, on flush, set count to 0 and deassert out_valid the next cycle, and ignore any input handshake on that edge; fmt_err is unaffected.
REQ-026 SHALL keep fmt_err set until reset; flush does not clear it.

Reset
REQ-027 SHALL, on reset_n low, asynchronously force count = 0, both pointers = 0, out_valid = 0, fmt_err = 0 and out_imm = 0.
REQ-028 SHALL force in_ready = 0 while reset_n is low and assert it on the first edge after reset_n rises.
REQ-029 SHALL discard in-flight entries on reset mid-operation; no stale value is presented after reset.

Structure
REQ-030 SHALL place the fmt encodings (imm_fmt_t enum), field bit positions and the legal-DATA_W constant in shared package imm_pkg.
REQ-031 SHALL implement field selection and extension in one combinational sub-module, imm_field_ext (parameter DATA_W); the FIFO and handshake logic stay in imm_extend_pipe.
REQ-032 SHALL assert at elaboration that DATA_W is 32 or 64 and DEPTH is 1 or 2.

Verification
REQ-033 Format sweep: DATA_W=64, push each fmt with instr=32'hFFFF_FFFF, out_ready=1 -> out_imm:
- IMM12: 0x0000_0000_0000_0FFF.
- DADDR9: 0xFFFF_FFFF_FFFF_FFFF.
- CB19: 0xFFFF_FFFF_FFFF_FFFC.
- B26: 0xFFFF_FFFF_FFFF_FFFC.
- MOV16 (hw=3): 0xFFFF_0000_0000_0000.
- SHAMT6: 0x3F.
Each appears 1 cycle after its push.
REQ-034 Backpressure: DEPTH=2, out_ready=0, push 3 entries -> in_ready drops after 2 pushes; raising out_ready drains the entries in order with no loss or duplication.
REQ-035 Streaming: DEPTH=2, in_valid=out_ready=1 for 100 cycles -> 100 outputs in order, in_ready never deasserts after the first output.
REQ-036 Flush: count=2, flush=1 with a simultaneous in_valid -> out_valid=0 next cycle, and the flushed-cycle input never appears at the output.
REQ-037 Illegal fmt: push fmt=7 -> out_imm=0, fmt_err=1 next cycle; fmt_err stays 1 through a flush and clears only on reset_n low.
REQ-038 Async reset: assert reset_n low between clock edges with count=2 -> out_valid and count are 0 immediately, and the first post-reset push produces the correct value 1 cycle later.
